// File: rtl/branch_checkpoint_table_pkg.sv
// Shared types and default sizing for the branch checkpoint table.
package branch_checkpoint_table_pkg;

    localparam int unsigned CKPT_NUM_DEFAULT = 4;
    localparam int unsigned CKPT_TAG_W       = 5;
    localparam int unsigned CKPT_NUM_PREGS   = 128;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               pc;
        logic [CKPT_TAG_W-1:0]     rob_tag;
        logic [CKPT_NUM_PREGS-1:0] rdy_table;
    } ckpt_entry_t;

endpackage

// File: rtl/branch_checkpoint_table_if.sv
// Rename/ROB/PRF-facing signal bundle of the branch checkpoint table.
// Map-table snapshot signals exist only when CKPT_MAP_SNAP_EN is defined.
interface branch_checkpoint_table_if
    import branch_checkpoint_table_pkg::*;
#(
    parameter int unsigned NUM_CKPT  = CKPT_NUM_DEFAULT,
    parameter int unsigned TAG_W     = CKPT_TAG_W,
    parameter int unsigned NUM_PREGS = CKPT_NUM_PREGS
`ifdef CKPT_MAP_SNAP_EN
    ,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PREG_W    = 7
`endif
);

    logic                          alloc_valid;
    logic                          alloc_ready;
    logic [31:0]                   alloc_pc;
    logic [TAG_W-1:0]              alloc_rob_tag;
    logic [NUM_PREGS-1:0]          alloc_rdy_snap;
    logic [$clog2(NUM_CKPT)-1:0]   alloc_id;
    logic                          resolve_valid;
    logic [TAG_W-1:0]              resolve_tag;
    logic                          mispredict;
    logic [TAG_W-1:0]              mispredict_tag;
    logic [TAG_W-1:0]              rob_head_tag;
    logic                          restore_valid;
    logic [31:0]                   restore_pc;
    logic [TAG_W-1:0]              restore_rob_tag;
    logic [NUM_PREGS-1:0]          restore_rdy;
    logic                          restore_miss;
    logic [$clog2(NUM_CKPT):0]     free_count;
    logic                          full;
`ifdef CKPT_MAP_SNAP_EN
    logic [ARCH_REGS*PREG_W-1:0]   alloc_map_snap;
    logic [ARCH_REGS*PREG_W-1:0]   restore_map;
`endif

    modport master (
        output alloc_valid, alloc_pc, alloc_rob_tag, alloc_rdy_snap,
        output resolve_valid, resolve_tag, mispredict, mispredict_tag, rob_head_tag,
        input  alloc_ready, alloc_id, restore_valid, restore_pc, restore_rob_tag,
        input  restore_rdy, restore_miss, free_count, full
`ifdef CKPT_MAP_SNAP_EN
        ,
        output alloc_map_snap,
        input  restore_map
`endif
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_rob_tag, alloc_rdy_snap,
        input  resolve_valid, resolve_tag, mispredict, mispredict_tag, rob_head_tag,
        output alloc_ready, alloc_id, restore_valid, restore_pc, restore_rob_tag,
        output restore_rdy, restore_miss, free_count, full
`ifdef CKPT_MAP_SNAP_EN
        ,
        input  alloc_map_snap,
        output restore_map
`endif
    );

endinterface

// File: rtl/branch_checkpoint_table_prio_enc.sv
// Lowest-set-bit finder: index of the lowest asserted request plus a found flag.
module ckpt_prio_enc #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_checkpoint_table.sv
// Branch checkpoint store: allocate on rename, free on resolve, restore and squash on mispredict.
// Optional macro CKPT_MAP_SNAP_EN adds rename-map snapshot storage and restore.
module branch_checkpoint_table
    import branch_checkpoint_table_pkg::*;
#(
    parameter int unsigned NUM_CKPT  = CKPT_NUM_DEFAULT,
    parameter int unsigned TAG_W     = CKPT_TAG_W,
    parameter int unsigned NUM_PREGS = CKPT_NUM_PREGS
`ifdef CKPT_MAP_SNAP_EN
    ,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PREG_W    = 7
`endif
) (
    input logic                   clk,
    input logic                   reset,
    branch_checkpoint_table_if.slave bus
);

    localparam int unsigned ID_W  = $clog2(NUM_CKPT);
    localparam int unsigned CNT_W = ID_W + 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic [TAG_W-1:0]     rob_tag;
        logic [NUM_PREGS-1:0] rdy_table;
    } entry_t;

    entry_t              ent_q [NUM_CKPT];
    entry_t              ent_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]    free_count_q, free_count_d;
    logic                full_q, full_d;
    logic                restore_valid_q, restore_valid_d;
    logic                restore_miss_q, restore_miss_d;
    entry_t              restore_q, restore_d;

    logic [NUM_CKPT-1:0] free_vec, match_vec;
    logic [ID_W-1:0]     free_idx, match_idx;
    logic                free_found, match_found;
    logic [TAG_W-1:0]    ent_age [NUM_CKPT];
    logic [TAG_W-1:0]    mp_age;
    logic                alloc_ready;
    logic                alloc_fire;
    logic                restore_hit;

    assign free_vec = ~valid_q;

    ckpt_prio_enc #(.N(NUM_CKPT)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    ckpt_prio_enc #(.N(NUM_CKPT)) u_match_enc (
        .req   (match_vec),
        .idx   (match_idx),
        .found (match_found)
    );

    // free_found mirrors !full_q; using it keeps the accept path off the count flops
    assign alloc_ready = free_found && !bus.mispredict;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign restore_hit = bus.mispredict && match_found;
    assign mp_age      = TAG_W'(bus.mispredict_tag - bus.rob_head_tag);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            match_vec[i] = valid_q[i] && (ent_q[i].rob_tag == bus.mispredict_tag);
            ent_age[i]   = TAG_W'(ent_q[i].rob_tag - bus.rob_head_tag);
        end
    end

    always_comb begin
        valid_d         = valid_q;
        ent_d           = ent_q;
        restore_d       = restore_q;
        restore_valid_d = restore_hit;
        restore_miss_d  = bus.mispredict && !match_found;
        free_count_d    = '0;

        // Resolve and squash only ever clear bits, so overlaps collapse to a single clear
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if (bus.resolve_valid && valid_q[i] && (ent_q[i].rob_tag == bus.resolve_tag))
                valid_d[i] = 1'b0;
            if (bus.mispredict && valid_q[i] && (ent_age[i] > mp_age))
                valid_d[i] = 1'b0;
        end
        if (restore_hit) begin
            valid_d[match_idx] = 1'b0;
            restore_d          = ent_q[match_idx];
        end
        if (alloc_fire) begin
            valid_d[free_idx] = 1'b1;
            ent_d[free_idx]   = '{pc: bus.alloc_pc, rob_tag: bus.alloc_rob_tag,
                                  rdy_table: bus.alloc_rdy_snap};
        end

        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if (!valid_d[i])
                free_count_d = free_count_d + CNT_W'(1);
        end
        full_d = &valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= '0;
            free_count_q    <= CNT_W'(NUM_CKPT);
            full_q          <= 1'b0;
            restore_valid_q <= 1'b0;
            restore_miss_q  <= 1'b0;
            restore_q       <= '0;
        end else begin
            valid_q         <= valid_d;
            free_count_q    <= free_count_d;
            full_q          <= full_d;
            restore_valid_q <= restore_valid_d;
            restore_miss_q  <= restore_miss_d;
            restore_q       <= restore_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

`ifdef CKPT_MAP_SNAP_EN
    localparam int unsigned MAP_W = ARCH_REGS * PREG_W;

    logic [MAP_W-1:0] map_q [NUM_CKPT];
    logic [MAP_W-1:0] map_d [NUM_CKPT];
    logic [MAP_W-1:0] restore_map_q, restore_map_d;

    always_comb begin
        map_d         = map_q;
        restore_map_d = restore_map_q;
        if (alloc_fire)
            map_d[free_idx] = bus.alloc_map_snap;
        if (restore_hit)
            restore_map_d = map_q[match_idx];
    end

    always_ff @(posedge clk) begin
        map_q <= map_d;
        if (reset)
            restore_map_q <= '0;
        else
            restore_map_q <= restore_map_d;
    end

    assign bus.restore_map = restore_map_q;
`endif

    assign bus.alloc_ready     = alloc_ready;
    assign bus.alloc_id        = free_idx;
    assign bus.restore_valid   = restore_valid_q;
    assign bus.restore_miss    = restore_miss_q;
    assign bus.restore_pc      = restore_q.pc;
    assign bus.restore_rob_tag = restore_q.rob_tag;
    assign bus.restore_rdy     = restore_q.rdy_table;
    assign bus.free_count      = free_count_q;
    assign bus.full            = full_q;

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Scoreboard bench for branch_checkpoint_table: directed scenarios then random traffic vs a table model.
module tb_branch_checkpoint_table;

    localparam int unsigned NC = 4;
    localparam int unsigned TW = 5;
    localparam int unsigned NP = 128;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    branch_checkpoint_table_if #(.NUM_CKPT(NC), .TAG_W(TW), .NUM_PREGS(NP)) bus ();

    branch_checkpoint_table #(.NUM_CKPT(NC), .TAG_W(TW), .NUM_PREGS(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit           miss;
        logic [31:0]  pc;
        logic [TW-1:0] tag;
        logic [NP-1:0] rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit            m_valid [NC];
    logic [31:0]   m_pc    [NC];
    int            m_tag   [NC];
    logic [NP-1:0] m_rdy   [NC];

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int age(input int t, input int h);
        return (t - h + 64) % 32;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NC; i++)
            if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int pick_tag();
        int i;
        if ($urandom_range(0, 3) != 0) begin
            i = $urandom_range(0, NC - 1);
            if (m_valid[i]) return m_tag[i];
        end
        return $urandom_range(0, 31);
    endfunction

    // One clock of stimulus: check registered/combinational outputs, then advance the model
    task automatic step(input bit av, input logic [31:0] pc, input int tag, input bit rv,
                        input int rtag, input bit mp, input int mtag, input int head, input bit rst);
        logic [NP-1:0] rdy;
        bit            nv [NC];
        int            slot, nfree, m;
        bit            ready_exp;
        exp_t          e;
        @(negedge clk);
        slot  = lowest_free();
        nfree = 0;
        for (int i = 0; i < NC; i++) if (!m_valid[i]) nfree++;
        check("free_count", NP'(bus.free_count), NP'(nfree));
        check("full", NP'(bus.full), NP'(nfree == 0));

        rdy                = {$urandom(), $urandom(), $urandom(), $urandom()};
        reset              = rst;
        bus.alloc_valid    = av;
        bus.alloc_pc       = pc;
        bus.alloc_rob_tag  = TW'(tag);
        bus.alloc_rdy_snap = rdy;
        bus.resolve_valid  = rv;
        bus.resolve_tag    = TW'(rtag);
        bus.mispredict     = mp;
        bus.mispredict_tag = TW'(mtag);
        bus.rob_head_tag   = TW'(head);
        #1;
        ready_exp = (nfree != 0) && !mp;
        check("alloc_ready", NP'(bus.alloc_ready), NP'(ready_exp));
        if (slot >= 0) check("alloc_id", NP'(bus.alloc_id), NP'(slot));

        if (rst) begin
            for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
            return;
        end
        nv = m_valid;
        if (mp) begin
            m = -1;
            for (int i = 0; i < NC; i++)
                if (m < 0 && m_valid[i] && m_tag[i] == mtag) m = i;
            e.miss = (m < 0);
            e.pc   = (m < 0) ? 32'h0 : m_pc[m];
            e.tag  = (m < 0) ? '0 : TW'(m_tag[m]);
            e.rdy  = (m < 0) ? '0 : m_rdy[m];
            exp_q.push_back(e);
            for (int i = 0; i < NC; i++)
                if (m_valid[i] && age(m_tag[i], head) > age(mtag, head)) nv[i] = 1'b0;
            if (m >= 0) nv[m] = 1'b0;
        end
        if (rv)
            for (int i = 0; i < NC; i++)
                if (m_valid[i] && m_tag[i] == rtag) nv[i] = 1'b0;
        if (av && ready_exp) begin
            nv[slot]    = 1'b1;
            m_pc[slot]  = pc;
            m_tag[slot] = tag;
            m_rdy[slot] = rdy;
        end
        m_valid = nv;
    endtask

    task automatic alloc(input int tag, input int head);
        step(1'b1, 32'(32'h1000 + tag * 4), tag, 1'b0, 0, 1'b0, 0, head, 1'b0);
    endtask

    task automatic idle(input int head);
        step(1'b0, 32'h0, 0, 1'b0, 0, 1'b0, 0, head, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic mispred(input int tag, input int head);
        step(1'b0, 32'h0, 0, 1'b0, 0, 1'b1, tag, head, 1'b0);
    endtask

    // Monitor: restore responses appear one edge after the mispredict, data holds otherwise
    initial begin
        logic [31:0]   last_pc  = '0;
        logic [TW-1:0] last_tag = '0;
        logic [NP-1:0] last_rdy = '0;
        exp_t          e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("restore_valid_rst", NP'(bus.restore_valid), NP'(0));
                check("restore_miss_rst", NP'(bus.restore_miss), NP'(0));
                last_pc  = '0;
                last_tag = '0;
                last_rdy = '0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("restore_valid", NP'(bus.restore_valid), NP'(!e.miss));
                check("restore_miss", NP'(bus.restore_miss), NP'(e.miss));
                if (!e.miss) begin
                    last_pc  = e.pc;
                    last_tag = e.tag;
                    last_rdy = e.rdy;
                end
            end else begin
                check("restore_valid_idle", NP'(bus.restore_valid), NP'(0));
                check("restore_miss_idle", NP'(bus.restore_miss), NP'(0));
            end
            check("restore_pc", NP'(bus.restore_pc), NP'(last_pc));
            check("restore_rob_tag", NP'(bus.restore_rob_tag), NP'(last_tag));
            check("restore_rdy", bus.restore_rdy, last_rdy);
        end
    end

    initial begin
        int  head, t, rt, mt;
        bit  av, rv, mp, rst;
        bus.alloc_valid    = 1'b0;
        bus.alloc_pc       = '0;
        bus.alloc_rob_tag  = '0;
        bus.alloc_rdy_snap = '0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_tag    = '0;
        bus.mispredict     = 1'b0;
        bus.mispredict_tag = '0;
        bus.rob_head_tag   = '0;
        for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;

        // Fill to full, then resolve-while-full blocks the same-cycle alloc
        do_reset();
        alloc(3, 0); alloc(7, 0); alloc(9, 0); alloc(12, 0);
        idle(0);
        step(1'b1, 32'h2000, 20, 1'b1, 7, 1'b0, 0, 0, 1'b0);
        idle(0);
        alloc(15, 0);
        idle(0);

        // Mispredict on a mid-age entry squashes it and everything younger
        do_reset();
        alloc(3, 0); alloc(7, 0); alloc(9, 0); alloc(12, 0);
        mispred(7, 0);
        idle(0);

        // Age wraps around the tag space
        do_reset();
        alloc(31, 30); alloc(1, 30); alloc(4, 30);
        mispred(31, 30);
        idle(30);

        // Unmatched mispredict still squashes younger entries
        do_reset();
        alloc(3, 0); alloc(25, 0);
        mispred(20, 0);
        idle(0);

        // Reset lands while restore_valid is high
        do_reset();
        alloc(3, 0);
        mispred(3, 0);
        do_reset();
        idle(0);

        head = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) head = $urandom_range(0, 31);
            av  = 1'($urandom_range(0, 1));
            t   = $urandom_range(0, 31);
            rv  = ($urandom_range(0, 3) == 0);
            rt  = pick_tag();
            mp  = ($urandom_range(0, 9) == 0);
            mt  = pick_tag();
            rst = ($urandom_range(0, 99) == 0);
            step(av, $urandom(), t, rv, rt, mp, mt, head, rst);
        end
        idle(head);
        idle(head);
        check("scoreboard_empty", NP'(exp_q.size()), NP'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
